// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of every signal that crosses the shared data-memory arbiter: the
// requester-side handshake (req/grant/bus fields) and the memory-side port.
//
// Signals:
//   req          N           per-requester request, held for the whole sequence
//   req_addr     N*ADDR_W    per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_wr_en    N           per-requester write enable
//   req_wdata    N*DATA_W    per-requester write data, flattened like req_addr
//   grant        N           one-hot grant (registered)
//   grant_id     ID_W        index of current owner, 0 when idle
//   busy         1           a grant is held
//   rdata        DATA_W      memory read data broadcast to all requesters
//   timeout_err  1           one-cycle pulse on a forced revoke
//   mem_address  ADDR_W      to memory
//   mem_wr_en    1           to memory
//   mem_data_out DATA_W      to memory
//   mem_data_in  DATA_W      from memory, valid one cycle after the address
//
// Modports:
//   slave  - the arbiter
//   master - everything around it (requester FSMs and memory wrapper)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int N      = 4,
   parameter int ID_W   = 2,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
);
   logic [N-1:0]        req;
   logic [N*ADDR_W-1:0] req_addr;
   logic [N-1:0]        req_wr_en;
   logic [N*DATA_W-1:0] req_wdata;
   logic [N-1:0]        grant;
   logic [ID_W-1:0]     grant_id;
   logic                busy;
   logic [DATA_W-1:0]   rdata;
   logic                timeout_err;
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_wr_en;
   logic [DATA_W-1:0]   mem_data_out;
   logic [DATA_W-1:0]   mem_data_in;

   modport slave (
      input  req, req_addr, req_wr_en, req_wdata, mem_data_in,
      output grant, grant_id, busy, rdata, timeout_err,
      output mem_address, mem_wr_en, mem_data_out
   );

   modport master (
      output req, req_addr, req_wr_en, req_wdata, mem_data_in,
      input  grant, grant_id, busy, rdata, timeout_err,
      input  mem_address, mem_wr_en, mem_data_out
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter sharing one single-port data memory between several
// requester FSMs. A requester keeps req high for its whole multi-cycle
// sequence; the grant is locked for that duration and then released through a
// one-cycle GAP state before the next owner is granted.
//
// Ports:
//   clock  - system clock, rising edge
//   nrst   - synchronous active-low reset
//   bus    - mem_port_arbiter_if.slave: requester handshake and memory port
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   - an owner holding the port for MAX_HOLD cycles is revoked,
//               timeout_err pulses, and that requester is masked from
//               arbitration until it has dropped req for a cycle.
//   undefined - grant is held for as long as req stays high; timeout_err = 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int N        = 4,
   parameter int ID_W     = 2,
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 16,
   parameter int MAX_HOLD = 1024
) (
   input logic               clock,
   input logic               nrst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OWNED = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam int              HC_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

   logic [1:0]        r_state;
   logic [N-1:0]      r_grant;
   logic [ID_W-1:0]   r_owner;
   logic              r_busy;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [HC_W-1:0]   r_hold_cnt;
   logic              r_timeout_err;
   logic [ADDR_W-1:0] r_last_addr;

   logic [N-1:0]      w_eligible;
   logic              w_pick_vld;
   logic [ID_W-1:0]   w_pick_id;
   logic [N-1:0]      w_pick_oh;
   logic              w_own_req;
   logic              w_own_wr;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_wdata;
   logic [ID_W-1:0]   w_next_ptr;
   logic              w_timeout;

   // Owner-side bus fields, muxed on the registered owner index.
   assign w_own_req   = bus.req[r_owner];
   assign w_own_wr    = bus.req_wr_en[r_owner];
   assign w_own_addr  = bus.req_addr[int'(r_owner) * ADDR_W +: ADDR_W];
   assign w_own_wdata = bus.req_wdata[int'(r_owner) * DATA_W +: DATA_W];
   assign w_next_ptr  = ID_W'((int'(r_owner) + 1) % N);

`ifdef ARB_TIMEOUT_EN
   localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD - 1);

   logic [N-1:0] r_mask;

   // Revoke only a live owner; a simultaneous voluntary release wins.
   assign w_timeout  = (r_state == ST_OWNED) && w_own_req && (r_hold_cnt == HOLD_LIM);
   assign w_eligible = bus.req & ~r_mask;

   // Mask a revoked requester until it has been seen with req low.
   always_ff @(posedge clock) begin
      if (!nrst) begin
         r_mask <= '0;
      end else if (w_timeout) begin
         r_mask <= (r_mask & bus.req) | r_grant;
      end else begin
         r_mask <= r_mask & bus.req;
      end
   end
`else
   assign w_timeout  = 1'b0;
   assign w_eligible = bus.req;
`endif

   // Round-robin search starting at r_rr_ptr; first eligible requester wins.
   always_comb begin
      int idx;
      idx        = 0;
      w_pick_vld = 1'b0;
      w_pick_id  = '0;
      w_pick_oh  = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(r_rr_ptr) + k) % N;
         if (!w_pick_vld && w_eligible[idx]) begin
            w_pick_vld     = 1'b1;
            w_pick_id      = ID_W'(idx);
            w_pick_oh[idx] = 1'b1;
         end else begin
            w_pick_vld = w_pick_vld;
         end
      end
   end

   // Arbitration state machine: IDLE -> OWNED -> GAP -> (OWNED | IDLE).
   always_ff @(posedge clock) begin
      if (!nrst) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_owner       <= '0;
         r_busy        <= 1'b0;
         r_rr_ptr      <= '0;
         r_hold_cnt    <= '0;
         r_timeout_err <= 1'b0;
         r_last_addr   <= '0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE, ST_GAP: begin
               if (w_pick_vld) begin
                  r_state    <= ST_OWNED;
                  r_grant    <= w_pick_oh;
                  r_owner    <= w_pick_id;
                  r_busy     <= 1'b1;
                  r_hold_cnt <= '0;
               end else begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_owner <= '0;
                  r_busy  <= 1'b0;
               end
            end
            ST_OWNED: begin
               // Remembered so mem_address can hold its value through GAP.
               r_last_addr <= w_own_addr;
               if (!w_own_req || w_timeout) begin
                  r_state       <= ST_GAP;
                  r_grant       <= '0;
                  r_owner       <= '0;
                  r_busy        <= 1'b0;
                  r_rr_ptr      <= w_next_ptr;
                  r_timeout_err <= w_timeout;
               end else if (r_hold_cnt != HOLD_MAX) begin
                  r_hold_cnt <= r_hold_cnt + HC_W'(1);
               end else begin
                  r_hold_cnt <= r_hold_cnt;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_owner <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Memory port drive: owner's fields while OWNED, held address in GAP, zero when idle.
   // nrst gates the write so a reset cycle can never commit a store.
   always_comb begin
      bus.mem_address  = '0;
      bus.mem_wr_en    = 1'b0;
      bus.mem_data_out = '0;
      case (r_state)
         ST_OWNED: begin
            bus.mem_address  = w_own_addr;
            bus.mem_data_out = w_own_wdata;
            bus.mem_wr_en    = w_own_wr & w_own_req & nrst;
         end
         ST_GAP: begin
            bus.mem_address = r_last_addr;
         end
         default: begin
            bus.mem_address = '0;
         end
      endcase
   end

   assign bus.grant       = r_grant;
   assign bus.grant_id    = r_owner;
   assign bus.busy        = r_busy;
   assign bus.timeout_err = r_timeout_err;
   assign bus.rdata       = bus.mem_data_in;
endmodule
